// File: rtl/banco_registro_sweep.sv
// Register bank with two combinational read ports, one write port, a one-word-per-cycle
// clear engine and a round-robin scan port that feeds the display mux.
module banco_registro_sweep #(
  parameter int unsigned BIT_ADDR = 3,
  parameter int unsigned BIT_DATO = 4,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] addrRa,
  input  logic [BIT_ADDR-1:0] addrRb,
  output logic [BIT_DATO-1:0] datOutRa,
  output logic [BIT_DATO-1:0] datOutRb,
  input  logic [BIT_ADDR-1:0] addrW,
  input  logic [BIT_DATO-1:0] datW,
  input  logic                we,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_drop,
  output logic [BIT_ADDR-1:0] scan_addr,
  output logic [BIT_DATO-1:0] scan_dat
);

  localparam int unsigned NREG = 2 ** BIT_ADDR;
  localparam int unsigned CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]       CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [BIT_ADDR-1:0] LAST_PTR = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q;
  logic [BIT_DATO-1:0]   breg_q [NREG];
  logic [BIT_ADDR-1:0]   clr_ptr_q;
  logic                  busy_q;
  logic                  wr_drop_q;
  logic [BIT_ADDR-1:0]   scan_addr_q, scan_addr_d;
  logic [CW-1:0]         scan_cnt_q, scan_cnt_d;
  logic                  fwd_en;

  // Single FSM block: bank contents, clear pointer and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) breg_q[i] <= '0;
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (we) breg_q[addrW] <= datW;
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          breg_q[clr_ptr_q] <= '0;
          wr_drop_q         <= we;
          if (clr_ptr_q == LAST_PTR) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clr_ptr_q <= '0;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    scan_addr_d = scan_addr_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d  = '0;
      scan_addr_d = scan_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      scan_addr_q <= '0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_addr_q <= scan_addr_d;
    end
  end

  // Forwarding only applies when the write will actually land this edge.
  assign fwd_en = BYPASS && we && (state_q == IDLE);

  assign datOutRa  = (fwd_en && addrRa == addrW) ? datW : breg_q[addrRa];
  assign datOutRb  = (fwd_en && addrRb == addrW) ? datW : breg_q[addrRb];
  assign busy      = busy_q;
  assign wr_drop   = wr_drop_q;
  assign scan_addr = scan_addr_q;
  assign scan_dat  = breg_q[scan_addr_q];

endmodule

// File: tb/tb_banco_registro_sweep.sv
// Directed bench for banco_registro_sweep: reset, write/forward, sweep clear,
// dropped writes, write+clear collision, scan wrap and reset during a sweep.
`timescale 1ns/1ps
module tb_banco_registro_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] addrRa = '0, addrRb = '0, addrW = '0;
  logic [3:0] datW = '0;
  logic       we = 1'b0, clr_req = 1'b0;
  logic [3:0] datOutRa, datOutRb, scan_dat;
  logic       busy, wr_drop;
  logic [2:0] scan_addr;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [3:0] mdl [8];

  banco_registro_sweep #(
    .BIT_ADDR(3),
    .BIT_DATO(4),
    .BYPASS  (1'b1),
    .SCAN_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addrRa   (addrRa),
    .addrRb   (addrRb),
    .datOutRa (datOutRa),
    .datOutRb (datOutRb),
    .addrW    (addrW),
    .datW     (datW),
    .we       (we),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_drop  (wr_drop),
    .scan_addr(scan_addr),
    .scan_dat (scan_dat)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    we = 1'b1; addrW = a; datW = d;
    tick();
    we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [3:0] exp);
    addrRa = a;
    #1;
    chk(tag, datOutRa, exp);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    cyc = 0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
  endtask

  initial begin
    // 1: asynchronous reset with no clock edge
    #2;
    pulse_rst();
    for (int i = 0; i < 8; i++) rd("rst_word", 3'(i), 4'd0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_scan_addr", scan_addr, 0);

    // 6: scan wrap, idle
    repeat (3) tick();
    chk("scan_3", scan_addr, 0);
    tick();
    chk("scan_4", scan_addr, 1);
    repeat (27) tick();
    chk("scan_31", scan_addr, 7);
    tick();
    chk("scan_32_wrap", scan_addr, 0);

    // 2: write with same-cycle forwarding
    we = 1'b1; addrW = 3'd5; datW = 4'd9; addrRa = 3'd5; addrRb = 3'd4;
    #1;
    chk("fwd_a", datOutRa, 9);
    chk("nofwd_b", datOutRb, 0);
    tick();
    we = 1'b0;
    mdl[5] = 4'd9;
    #1;
    chk("rd_after_wr", datOutRa, 9);

    // 3: fill 1..8 then sweep clear
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 1));
    for (int i = 0; i < 8; i++) rd("fill_word", 3'(i), 4'(i + 1));
    chk("scan_dat_fill", scan_dat, mdl[(cyc / 4) % 8]);
    chk("scan_addr_model", scan_addr, 3'((cyc / 4) % 8));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("busy_start", busy, 1);
    repeat (3) tick();
    addrRa = 3'd2; addrRb = 3'd3;
    #1;
    chk("swept_w2", datOutRa, 0);
    chk("unswept_w3", datOutRb, 4);

    // 4: write during clear is dropped, no forwarding; clr_req ignored
    we = 1'b1; addrW = 3'd6; datW = 4'd12; addrRb = 3'd6; clr_req = 1'b1;
    #1;
    chk("busy_nofwd", datOutRb, 7);
    tick();
    we = 1'b0;
    #1;
    chk("wr_drop_pulse", wr_drop, 1);
    chk("busy_w6_kept", datOutRb, 7);
    tick();
    chk("wr_drop_clear", wr_drop, 0);
    repeat (2) tick();
    chk("busy_rise7", busy, 1);
    tick();
    clr_req = 1'b0;
    chk("busy_done", busy, 0);
    for (int i = 0; i < 8; i++) rd("cleared_word", 3'(i), 4'd0);
    tick();
    chk("no_restart", busy, 0);

    // 5: write and clear request on the same edge
    we = 1'b1; addrW = 3'd2; datW = 4'd10; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    rd("coll_wr_lands", 3'd2, 4'd10);
    chk("coll_busy", busy, 1);
    chk("coll_wr_drop", wr_drop, 0);
    repeat (3) tick();
    rd("coll_swept", 3'd2, 4'd0);
    repeat (5) tick();
    chk("coll_done", busy, 0);

    // reset in the middle of a sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 8));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (2) tick();
    rd("pre_rst_w5", 3'd5, 4'd13);
    pulse_rst();
    chk("midrst_busy", busy, 0);
    chk("midrst_scan", scan_addr, 0);
    for (int i = 0; i < 8; i++) rd("midrst_word", 3'(i), 4'd0);
    wr(3'd1, 4'd6);
    rd("post_rst_wr", 3'd1, 4'd6);
    chk("post_rst_wr_drop", wr_drop, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
